// File: rtl/dm_access_unit_if.sv
// Core-to-data-memory access bus: request codes, address and store data in,
// stall, load result and misalignment pulse out.
interface dm_access_unit_if;
  logic        req_valid;
  logic [1:0]  DMWr;
  logic [2:0]  DMRe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misalign;

  modport master (
    output req_valid, DMWr, DMRe, addr, wdata,
    input  stall, rdata, rvalid, misalign
  );

  modport slave (
    input  req_valid, DMWr, DMRe, addr, wdata,
    output stall, rdata, rvalid, misalign
  );
endinterface

// File: rtl/dm_access_unit.sv
// Data-memory responder: word-wide single-port synchronous RAM with sub-word
// loads (sign/zero extended) and read-modify-write sub-word stores.
module dm_access_unit #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  dm_access_unit_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;
  typedef enum logic [3:0] {
    OP_NONE, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
  } op_t;

  state_t              state, state_nxt;
  op_t                 req_op, op_q;
  logic                req_half, req_word, req_mis, req_go, req_multi, req_sw;
  logic [IDX_W-1:0]    req_idx, idx_q, ram_idx;
  logic [1:0]          off_q;
  logic [15:0]         wdata_q;
  logic [DATA_W-1:0]   rdata_q, ram_rd, ram_wd, load_ext, merged;
  logic                rvalid_q, misalign_q, op_is_load;
  logic                stall_c, ram_we, ram_re;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic                unused_addr;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign req_idx     = bus.addr[ADDR_W-1:2];
  assign unused_addr = ^bus.addr[31:ADDR_W];

  // Request decode; a store code takes priority over a load code.
  always_comb begin
    req_op = OP_NONE;
    if (bus.DMWr != 2'b00) begin
      case (bus.DMWr)
        2'b01:   req_op = OP_SB;
        2'b10:   req_op = OP_SH;
        default: req_op = OP_SW;
      endcase
    end else begin
      case (bus.DMRe)
        3'd1:    req_op = OP_LB;
        3'd2:    req_op = OP_LBU;
        3'd3:    req_op = OP_LH;
        3'd4:    req_op = OP_LHU;
        3'd5:    req_op = OP_LW;
        default: req_op = OP_NONE;
      endcase
    end
  end

  assign req_half  = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
  assign req_word  = (req_op == OP_LW) || (req_op == OP_SW);
  assign req_mis   = bus.req_valid &&
                     ((req_half && bus.addr[0]) || (req_word && (bus.addr[1:0] != 2'b00)));
  assign req_go    = bus.req_valid && !req_mis && (req_op != OP_NONE);
  assign req_multi = req_go && (req_op != OP_SW);
  assign req_sw    = req_go && (req_op == OP_SW);

  assign op_is_load = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_LH) ||
                      (op_q == OP_LHU) || (op_q == OP_LW);

  // Lane extraction and merge operate on the word read during the IDLE cycle.
  assign lane_b = ram_rd[{off_q, 3'b000} +: 8];
  assign lane_h = ram_rd[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = ram_rd;
    case (op_q)
      OP_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_ext = {24'd0, lane_b};
      OP_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_ext = {16'd0, lane_h};
      default: load_ext = ram_rd;
    endcase
  end

  always_comb begin
    merged = ram_rd;
    if (op_q == OP_SB) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    if (op_q == OP_SH) merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_multi) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port control; reset suppresses any write in flight.
  always_comb begin
    stall_c = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    ram_idx = req_idx;
    ram_wd  = bus.wdata;
    case (state)
      IDLE: begin
        stall_c = req_multi;
        ram_re  = req_multi && !rst;
        ram_we  = req_sw && !rst;
      end
      RD_WAIT: begin
        stall_c = 1'b1;
        ram_idx = idx_q;
        ram_wd  = merged;
        ram_we  = !rst && ((op_q == OP_SB) || (op_q == OP_SH));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_NONE;
      off_q      <= 2'd0;
      wdata_q    <= 16'd0;
      idx_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rvalid_q   <= 1'b0;
      misalign_q <= (state == IDLE) && req_mis;
      if ((state == IDLE) && req_multi) begin
        op_q    <= req_op;
        off_q   <= bus.addr[1:0];
        wdata_q <= bus.wdata[15:0];
        idx_q   <= req_idx;
      end
      if ((state == RD_WAIT) && op_is_load) begin
        rdata_q  <= load_ext;
        rvalid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= ram_wd;
    if (ram_re) ram_rd <= mem[ram_idx];
  end

  assign bus.stall    = stall_c;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: directed vector table, reset corner sequences and
// random accesses checked against a byte-lane memory model.
module tb_dm_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_access_unit_if bus();

  dm_access_unit #(.ADDR_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  wr;
    logic [2:0]  re;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    bit          rv;
    logic [31:0] rdata;
    bit          mis;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rv_cyc = 0;
  bit          pend_mis = 1'b0;
  bit          prev_load = 1'b0;
  logic [31:0] model_mem [16];
  logic [31:0] model_rdata;
  vec_t        tbl [$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [1:0] wr, input logic [2:0] re,
                              input logic [31:0] a, input logic [31:0] d,
                              input int st, input bit rv, input logic [31:0] rd,
                              input bit mis);
    vec_t v;
    v.wr = wr; v.re = re; v.addr = a; v.wdata = d;
    v.stalls = st; v.rv = rv; v.rdata = rd; v.mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h exp %08h", name, got, exp);
    end
  endtask

  // Present one request, hold it while stalled, check the retire cycle.
  task automatic access(input vec_t v, input string tag);
    int st;
    bit done;
    st = 0;
    done = 1'b0;
    bus.req_valid = 1'b1;
    bus.DMWr = v.wr;
    bus.DMRe = v.re;
    bus.addr = v.addr;
    bus.wdata = v.wdata;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk({tag, " misalign"}, 32'(bus.misalign), 32'((c == 0) ? pend_mis : 1'b0));
      if (!bus.stall) begin
        done = 1'b1;
        break;
      end
      chk({tag, " rvalid_while_stalled"}, 32'(bus.rvalid), 32'd0);
      st++;
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s stall_timeout got %0d cycles exp %0d", tag, st, v.stalls);
    end else begin
      chk({tag, " stall_cycles"}, 32'(st), 32'(v.stalls));
      chk({tag, " rvalid"}, 32'(bus.rvalid), 32'(v.rv));
      chk({tag, " rdata"}, bus.rdata, v.rdata);
      if (v.rv && prev_load) chk({tag, " rvalid_spacing"}, 32'(cyc - last_rv_cyc), 32'd3);
      if (bus.rvalid) last_rv_cyc = cyc;
    end
    prev_load = v.rv;
    pend_mis = v.mis;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    bus.req_valid = 1'b0;
    bus.DMWr = 2'b00;
    bus.DMRe = 3'b000;
    #1;
    chk({tag, " misalign"}, 32'(bus.misalign), 32'(pend_mis));
    chk({tag, " stall"}, 32'(bus.stall), 32'd0);
    chk({tag, " rvalid"}, 32'(bus.rvalid), 32'd0);
    pend_mis = 1'b0;
    prev_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: byte-lane memory of 16 words, addressed by a[5:2].
  task automatic model(input logic [1:0] wr, input logic [2:0] re,
                       input logic [31:0] a, input logic [31:0] d, output vec_t v);
    int unsigned size, sh, idx;
    logic [31:0] w, mask, val;
    idx = 32'(a[5:2]);
    sh = 8 * (a % 4);
    if (wr != 2'd0) size = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
    else if (re == 3'd1 || re == 3'd2) size = 1;
    else if (re == 3'd3 || re == 3'd4) size = 2;
    else if (re == 3'd5) size = 4;
    else size = 0;
    v = mk(wr, re, a, d, 0, 1'b0, model_rdata, 1'b0);
    if (size == 0) begin
      v.stalls = 0;
    end else if ((a % size) != 0) begin
      v.mis = 1'b1;
    end else if (wr != 2'd0) begin
      if (size == 4) begin
        model_mem[idx] = d;
      end else begin
        mask = (size == 1) ? 32'hFF : 32'hFFFF;
        model_mem[idx] = (model_mem[idx] & ~(mask << sh)) | ((d & mask) << sh);
        v.stalls = 2;
      end
    end else begin
      w = model_mem[idx] >> sh;
      case (re)
        3'd1: begin val = w & 32'hFF;   if (val >= 128)   val = val - 32'd256; end
        3'd2: val = w & 32'hFF;
        3'd3: begin val = w & 32'hFFFF; if (val >= 32768) val = val - 32'd65536; end
        3'd4: val = w & 32'hFFFF;
        default: val = model_mem[idx];
      endcase
      model_rdata = val;
      v.stalls = 2;
      v.rv = 1'b1;
      v.rdata = val;
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] a;

    tbl.push_back(mk(2'd3, 3'd0, 32'h10,   32'h12345678, 0, 1'b0, 32'h0,        1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h10,   32'h0,        2, 1'b1, 32'h12345678, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 32'h11,   32'hDEADBEAB, 2, 1'b0, 32'h12345678, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h10,   32'h0,        2, 1'b1, 32'h1234AB78, 1'b0));
    tbl.push_back(mk(2'd0, 3'd1, 32'h11,   32'h0,        2, 1'b1, 32'hFFFFFFAB, 1'b0));
    tbl.push_back(mk(2'd0, 3'd2, 32'h11,   32'h0,        2, 1'b1, 32'h000000AB, 1'b0));
    tbl.push_back(mk(2'd2, 3'd0, 32'h12,   32'h12348001, 2, 1'b0, 32'h000000AB, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h10,   32'h0,        2, 1'b1, 32'h8001AB78, 1'b0));
    tbl.push_back(mk(2'd0, 3'd3, 32'h12,   32'h0,        2, 1'b1, 32'hFFFF8001, 1'b0));
    tbl.push_back(mk(2'd0, 3'd4, 32'h12,   32'h0,        2, 1'b1, 32'h00008001, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h13,   32'h0,        0, 1'b0, 32'h00008001, 1'b1));
    tbl.push_back(mk(2'd2, 3'd0, 32'h11,   32'h5555,     0, 1'b0, 32'h00008001, 1'b1));
    tbl.push_back(mk(2'd0, 3'd5, 32'h10,   32'h0,        2, 1'b1, 32'h8001AB78, 1'b0));
    tbl.push_back(mk(2'd3, 3'd0, 32'h1014, 32'hCAFEF00D, 0, 1'b0, 32'h8001AB78, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h014,  32'h0,        2, 1'b1, 32'hCAFEF00D, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h10,   32'h0,        2, 1'b1, 32'h8001AB78, 1'b0));
    tbl.push_back(mk(2'd3, 3'd1, 32'h20,   32'h11223344, 0, 1'b0, 32'h8001AB78, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h20,   32'h0,        2, 1'b1, 32'h11223344, 1'b0));
    tbl.push_back(mk(2'd0, 3'd6, 32'h33,   32'h0,        0, 1'b0, 32'h11223344, 1'b0));
    tbl.push_back(mk(2'd1, 3'd5, 32'h21,   32'h99,       2, 1'b0, 32'h11223344, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 32'h20,   32'h0,        2, 1'b1, 32'h11229944, 1'b0));

    bus.req_valid = 1'b0;
    bus.DMWr = 2'b00;
    bus.DMRe = 3'b000;
    bus.addr = 32'h0;
    bus.wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset rvalid", 32'(bus.rvalid), 32'd0);
    chk("reset misalign", 32'(bus.misalign), 32'd0);
    chk("reset rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) access(tbl[i], $sformatf("vec%0d", i));
    idle("post_table");

    // Reset during RD_WAIT of an SB: merge write must not land.
    bus.req_valid = 1'b1; bus.DMWr = 2'd1; bus.DMRe = 3'd0;
    bus.addr = 32'h10; bus.wdata = 32'hFF;
    #1;
    chk("rstwait idle_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstwait rdwait_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; bus.req_valid = 1'b0; bus.DMWr = 2'd0;
    #1;
    chk("rstwait after_stall", 32'(bus.stall), 32'd0);
    chk("rstwait after_rdata", bus.rdata, 32'd0);
    chk("rstwait after_rvalid", 32'(bus.rvalid), 32'd0);
    @(posedge clk); @(negedge clk);
    pend_mis = 1'b0; prev_load = 1'b0;
    access(mk(2'd0, 3'd5, 32'h10, 32'h0, 2, 1'b1, 32'h8001AB78, 1'b0), "rstwait_lw");

    // Reset in IDLE with an SW presented: the write must not land.
    bus.req_valid = 1'b1; bus.DMWr = 2'd3; bus.DMRe = 3'd0;
    bus.addr = 32'h10; bus.wdata = 32'h0;
    rst = 1'b1;
    #1;
    chk("rstsw stall", 32'(bus.stall), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; bus.req_valid = 1'b0; bus.DMWr = 2'd0;
    @(posedge clk); @(negedge clk);
    pend_mis = 1'b0; prev_load = 1'b0;
    access(mk(2'd0, 3'd5, 32'h10, 32'h0, 2, 1'b1, 32'h8001AB78, 1'b0), "rstsw_lw");

    // Random phase against the reference model.
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_rdata = 32'h0;
    pend_mis = 1'b0;
    prev_load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'(i) << 2);
      model(2'd3, 3'd0, a, $urandom, v);
      access(v, $sformatf("init%0d", i));
    end
    for (int n = 0; n < 300; n++) begin
      logic [1:0] wr;
      logic [2:0] re;
      if ($urandom_range(0, 7) == 0) idle($sformatf("rnd_idle%0d", n));
      wr = ($urandom_range(0, 9) < 4) ? 2'($urandom_range(1, 3)) : 2'd0;
      re = 3'($urandom_range(0, 7));
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
          32'($urandom_range(0, 3));
      model(wr, re, a, $urandom, v);
      access(v, $sformatf("rnd%0d", n));
    end
    idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
